// File: rtl/fb_pkg.sv
// fb_pkg: shared types and default geometry for the framebuffer scan reader.
// Holds the scan FSM state enum and default address/timing constants.
package fb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_FEND = 2'd2
  } fb_state_e;

  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_STRIDE   = 256;

endpackage

// File: rtl/fb_valid_pipe.sv
// fb_valid_pipe: delays valid/frame_start/line_end by RD_LAT+1 stages.
// Ports: clk, rst_n (async low), i_vld/i_fs/i_le in, o_vld/o_fs/o_le out,
//        o_load = valid one stage before the output (pixel capture strobe).
module fb_valid_pipe
  import fb_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_vld,
  input  logic i_fs,
  input  logic i_le,
  output logic o_vld,
  output logic o_fs,
  output logic o_le,
  output logic o_load
);

  localparam int N = RD_LAT + 1;

  // Each stage is {le, fs, vld}; stage 0 in the low bits.
  logic [3*N-1:0] r_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh <= '0;
    end else begin
      r_sh <= {r_sh[3*N-4:0], i_le, i_fs, i_vld};
    end
  end

  assign {o_le, o_fs, o_vld} = r_sh[3*N-1 -: 3];

  // RAM data for a word is on mem_rdata while its flag sits
  // in the stage just before the output.
  assign o_load = r_sh[3*(N-2)];

endmodule

// File: rtl/fb_scan_reader.sv
// fb_scan_reader: raster-scans a double-buffered framebuffer over a RAM port.
// Ports: clk, reset (async low), enable, pix_tick, base0/base1, swap_req,
//        mem_addr/mem_rdata, pixel/pixel_valid, x/y, frame_start, line_end,
//        active_buf.
module fb_scan_reader
  import fb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = 32,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int STRIDE   = DEF_STRIDE,
  parameter int RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              pix_tick,
  input  logic [ADDR_W-1:0] base0,
  input  logic [ADDR_W-1:0] base1,
  input  logic              swap_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pixel,
  output logic              pixel_valid,
  output logic [15:0]       x,
  output logic [15:0]       y,
  output logic              frame_start,
  output logic              line_end,
  output logic              active_buf
);

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  fb_state_e r_state;
  fb_state_e w_next;

  logic [15:0]       r_x;
  logic [15:0]       r_y;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_pixel;
  logic              r_buf;
  logic              r_pend;

  logic              w_issue;
  logic              w_xlast;
  logic              w_ylast;
  logic              w_fs;
  logic              w_le;
  logic              w_load;
  logic              w_buf_new;
  logic [ADDR_W-1:0] w_base_cur;
  logic [ADDR_W-1:0] w_base_new;

  assign w_xlast = (r_x == X_LAST);
  assign w_ylast = (r_y == Y_LAST);
  assign w_fs = w_issue && (r_x == '0) && (r_y == '0);
  assign w_le = w_issue && w_xlast;

  // A request in the frame-end cycle itself still counts.
  assign w_buf_new = r_buf ^ (r_pend | swap_req);
  assign w_base_cur = r_buf ? base1 : base0;
  assign w_base_new = w_buf_new ? base1 : base0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_issue = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_SCAN;
      end
      S_SCAN: begin
        if (enable && pix_tick) begin
          w_issue = 1'b1;
          if (w_xlast && w_ylast) w_next = S_FEND;
        end
      end
      S_FEND: begin
        w_next = enable ? S_SCAN : S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x <= '0;
      r_y <= '0;
      r_line_base <= '0;
      r_addr <= '0;
      r_buf <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_pend <= (r_state == S_FEND) ? 1'b0 : (r_pend | swap_req);
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_x <= '0;
            r_y <= '0;
            r_line_base <= w_base_cur;
            r_addr <= w_base_cur;
          end
        end
        S_SCAN: begin
          if (w_issue) begin
            if (w_xlast) begin
              r_x <= '0;
              if (w_ylast) begin
                r_y <= '0;
              end else begin
                r_y <= r_y + 16'd1;
                r_line_base <= r_line_base + STEP;
                r_addr <= r_line_base + STEP;
              end
            end else begin
              r_x <= r_x + 16'd1;
              r_addr <= r_addr + ONE;
            end
          end
        end
        S_FEND: begin
          r_buf <= w_buf_new;
          r_x <= '0;
          r_y <= '0;
          r_line_base <= w_base_new;
          r_addr <= w_base_new;
        end
        default: begin
          r_x <= '0;
          r_y <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pixel <= '0;
    end else if (w_load) begin
      r_pixel <= mem_rdata;
    end
  end

  fb_valid_pipe #(
    .RD_LAT (RD_LAT)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (reset),
    .i_vld  (w_issue),
    .i_fs   (w_fs),
    .i_le   (w_le),
    .o_vld  (pixel_valid),
    .o_fs   (frame_start),
    .o_le   (line_end),
    .o_load (w_load)
  );

  assign mem_addr = r_addr;
  assign pixel = r_pixel;
  assign x = r_x;
  assign y = r_y;
  assign active_buf = r_buf;

endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: directed-vector bench for fb_scan_reader.
// Runs RD_LAT=1 and RD_LAT=2 instances side by side on one stimulus.
module tb_fb_scan_reader;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic        tk;
    logic        sw;
    logic        iss;
    logic        ca;
    logic [15:0] addr;
    logic [15:0] x;
    logic [15:0] y;
    logic        ab;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic pix_tick = 1'b0;
  logic swap_req = 1'b0;
  logic [15:0] base0 = 16'h0100;
  logic [15:0] base1 = 16'h0200;

  logic [15:0] a_addr, b_addr;
  logic [31:0] a_rd, b_rd, b_p;
  logic [31:0] a_pix, b_pix;
  logic a_pv, b_pv, a_fs, b_fs, a_le, b_le;
  logic a_ab, b_ab;
  logic [15:0] a_x, a_y, b_x, b_y;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  vec_t q[$];
  vec_t d0 = '0;
  vec_t d1 = '0;
  vec_t d2 = '0;

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {~a, a};
  endfunction

  fb_scan_reader #(
    .ADDR_W(16), .DATA_W(32), .H_ACTIVE(4), .V_ACTIVE(2),
    .STRIDE(8), .RD_LAT(1)
  ) u_a (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(pix_tick),
    .base0(base0), .base1(base1), .swap_req(swap_req),
    .mem_addr(a_addr), .mem_rdata(a_rd), .pixel(a_pix),
    .pixel_valid(a_pv), .x(a_x), .y(a_y), .frame_start(a_fs),
    .line_end(a_le), .active_buf(a_ab)
  );

  fb_scan_reader #(
    .ADDR_W(16), .DATA_W(32), .H_ACTIVE(4), .V_ACTIVE(2),
    .STRIDE(8), .RD_LAT(2)
  ) u_b (
    .clk(clk), .reset(reset), .enable(enable), .pix_tick(pix_tick),
    .base0(base0), .base1(base1), .swap_req(swap_req),
    .mem_addr(b_addr), .mem_rdata(b_rd), .pixel(b_pix),
    .pixel_valid(b_pv), .x(b_x), .y(b_y), .frame_start(b_fs),
    .line_end(b_le), .active_buf(b_ab)
  );

  always #5 clk = ~clk;

  // RAM models: 1-cycle and 2-cycle read latency.
  always @(posedge clk) begin
    a_rd <= pat(a_addr);
    b_p <= pat(b_addr);
    b_rd <= b_p;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL c%0d %s got %h exp %h", cyc, tag, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic en,
                              input logic tk, input logic sw,
                              input logic iss, input logic ca,
                              input logic [15:0] a, input logic [15:0] xx,
                              input logic [15:0] yy, input logic ab);
    vec_t v;
    v.rst = rst; v.en = en; v.tk = tk; v.sw = sw;
    v.iss = iss; v.ca = ca; v.addr = a;
    v.x = xx; v.y = yy; v.ab = ab;
    return v;
  endfunction

  task automatic vr();
    q.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0));
  endtask

  task automatic vn(input logic en, input logic tk, input logic sw,
                    input logic ab);
    q.push_back(mk(0, en, tk, sw, 0, 0, 16'h0, 16'h0, 16'h0, ab));
  endtask

  task automatic vi(input logic sw, input logic [15:0] a,
                    input logic [15:0] xx, input logic [15:0] yy,
                    input logic ab);
    q.push_back(mk(0, 1, 1, sw, 1, 1, a, xx, yy, ab));
  endtask

  task automatic vh(input logic en, input logic tk, input logic [15:0] a,
                    input logic [15:0] xx, input logic [15:0] yy,
                    input logic ab);
    q.push_back(mk(0, en, tk, 0, 0, 1, a, xx, yy, ab));
  endtask

  function automatic logic fs_of(input vec_t v);
    return v.iss && (v.x == 16'd0) && (v.y == 16'd0);
  endfunction

  function automatic logic le_of(input vec_t v);
    return v.iss && (v.x == 16'd3);
  endfunction

  task automatic run();
    while (q.size() > 0) begin
      vec_t v;
      v = q.pop_front();
      reset = !v.rst;
      enable = v.en;
      pix_tick = v.tk;
      swap_req = v.sw;
      if (v.rst) begin
        #1;
        check("rst addr_a", 32'(a_addr), 32'd0);
        check("rst addr_b", 32'(b_addr), 32'd0);
        check("rst x", 32'(a_x), 32'd0);
        check("rst y", 32'(a_y), 32'd0);
        check("rst pv_a", 32'(a_pv), 32'd0);
        check("rst pv_b", 32'(b_pv), 32'd0);
        check("rst fs", 32'({a_fs, b_fs}), 32'd0);
        check("rst le", 32'({a_le, b_le}), 32'd0);
        check("rst pix_a", a_pix, 32'd0);
        check("rst pix_b", b_pix, 32'd0);
        check("rst ab", 32'({a_ab, b_ab}), 32'd0);
        d0 = '0;
        d1 = '0;
        d2 = '0;
      end else begin
        check("pv_a", 32'(a_pv), 32'(d1.iss));
        check("fs_a", 32'(a_fs), 32'(fs_of(d1)));
        check("le_a", 32'(a_le), 32'(le_of(d1)));
        if (d1.iss) check("pix_a", a_pix, pat(d1.addr));
        check("pv_b", 32'(b_pv), 32'(d2.iss));
        check("fs_b", 32'(b_fs), 32'(fs_of(d2)));
        check("le_b", 32'(b_le), 32'(le_of(d2)));
        if (d2.iss) check("pix_b", b_pix, pat(d2.addr));
        check("ab", 32'(a_ab), 32'(v.ab));
        if (v.ca) begin
          check("addr", 32'(a_addr), 32'(v.addr));
          check("x", 32'(a_x), 32'(v.x));
          check("y", 32'(a_y), 32'(v.y));
        end
      end
      d2 = d1;
      d1 = d0;
      d0 = v;
      cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b0;
    @(negedge clk);
    // Frame on base0, swap requested mid-frame.
    vr();
    vn(0, 1, 0, 0);
    vn(1, 1, 0, 0);
    vi(0, 16'h0100, 0, 0, 0);
    vi(0, 16'h0101, 1, 0, 0);
    vi(0, 16'h0102, 2, 0, 0);
    vi(0, 16'h0103, 3, 0, 0);
    vi(0, 16'h0108, 0, 1, 0);
    vi(1, 16'h0109, 1, 1, 0);
    vi(0, 16'h010A, 2, 1, 0);
    vi(0, 16'h010B, 3, 1, 0);
    vn(1, 1, 0, 0);
    // Frame on base1 with a 5-cycle stall at x=2.
    vi(0, 16'h0200, 0, 0, 1);
    vi(0, 16'h0201, 1, 0, 1);
    repeat (5) vh(0, 1, 16'h0202, 2, 0, 1);
    vi(0, 16'h0202, 2, 0, 1);
    vi(0, 16'h0203, 3, 0, 1);
    vi(0, 16'h0208, 0, 1, 1);
    vi(1, 16'h0209, 1, 1, 1);
    vi(1, 16'h020A, 2, 1, 1);
    vi(0, 16'h020B, 3, 1, 1);
    vn(0, 0, 0, 1);
    vn(0, 0, 0, 0);
    vn(0, 0, 0, 0);
    run();
    // Address wrap, swap in the frame-end cycle, mid-frame reset.
    base0 = 16'hFFFE;
    vn(1, 1, 0, 0);
    vi(0, 16'hFFFE, 0, 0, 0);
    vi(0, 16'hFFFF, 1, 0, 0);
    vi(0, 16'h0000, 2, 0, 0);
    vi(0, 16'h0001, 3, 0, 0);
    vi(0, 16'h0006, 0, 1, 0);
    vi(0, 16'h0007, 1, 1, 0);
    vi(0, 16'h0008, 2, 1, 0);
    vi(0, 16'h0009, 3, 1, 0);
    vn(1, 1, 1, 0);
    vi(0, 16'h0200, 0, 0, 1);
    vi(0, 16'h0201, 1, 0, 1);
    vi(0, 16'h0202, 2, 0, 1);
    vi(0, 16'h0203, 3, 0, 1);
    vi(0, 16'h0208, 0, 1, 1);
    vi(0, 16'h0209, 1, 1, 1);
    vi(0, 16'h020A, 2, 1, 1);
    vr();
    vn(0, 0, 0, 0);
    vn(1, 1, 0, 0);
    vi(0, 16'hFFFE, 0, 0, 0);
    vi(0, 16'hFFFF, 1, 0, 0);
    vh(0, 0, 16'h0000, 2, 0, 0);
    vh(0, 1, 16'h0000, 2, 0, 0);
    vh(0, 0, 16'h0000, 2, 0, 0);
    run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fb_scan_reader.md
FB_SCAN_READER -- requirements
Module: fb_scan_reader

Interface
REQ-001 Parameter ADDR_W, default 16, width of the framebuffer word address.
REQ-002 Parameter DATA_W, default 32, width of one framebuffer word and pixel output.
REQ-003 Parameter H_ACTIVE, default 256, pixels per line.
REQ-004 Parameter V_ACTIVE, default 256, lines per frame.
REQ-005 Parameter STRIDE, default 256, words between line starts; STRIDE >= H_ACTIVE.
REQ-006 Parameter RD_LAT, default 1, RAM read latency in cycles, 1 or 2.
REQ-007 clk  in  1  single clock; all logic on its rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 enable  in  1  permits starting and continuing a scan.
REQ-010 pix_tick  in  1  one-cycle strobe; each strobe advances the scan one pixel.
REQ-011 base0, base1  in  ADDR_W each  start addresses of buffers 0 and 1.
REQ-012 swap_req  in  1  one-cycle request to change buffers at the next frame end.
REQ-013 mem_addr  out  ADDR_W  read address to RAM port B.
REQ-014 mem_rdata  in  DATA_W  RAM port B read data.
REQ-015 pixel  out  DATA_W  pixel word, registered.
REQ-016 pixel_valid  out  1  pixel holds data for the pixel issued RD_LAT+1 cycles earlier.
REQ-017 x, y  out  16 each  coordinates of the address issued this cycle.
REQ-018 frame_start, line_end  out  1 each  one-cycle markers aligned with pixel_valid.
REQ-019 active_buf  out  1  buffer being scanned.

Function
REQ-020 FSM states: IDLE, SCAN, FRAME_END.
- IDLE -> SCAN when enable=1; x=0, y=0, mem_addr=base[active_buf].
REQ-021 In SCAN, a pix_tick with enable=1 issues mem_addr, then increments x.
- At x=H_ACTIVE-1: x wraps to 0, y increments, line_base += STRIDE.
REQ-022 mem_addr = line_base + x, computed incrementally with no multiplier; sums wrap modulo 2^ADDR_W.
REQ-023 The tick at x=H_ACTIVE-1, y=V_ACTIVE-1 issues the last address, then the FSM enters FRAME_END for exactly one cycle.
REQ-024 In FRAME_END: if swap is pending, active_buf toggles and pending clears; x, y and line_base reload from the new base.
- Next state is SCAN if enable=1, else IDLE.
REQ-025 swap_req sets a pending flag in any state.
- A request arriving in the same cycle as FRAME_END is applied at that frame end.
- Repeated requests before a frame end collapse into one toggle.
REQ-026 enable=0 in SCAN freezes x, y and address (stall), ignores pix_tick, and emits no new pixel_valid; enable=1 resumes from the same pixel.
REQ-027 pix_tick is ignored in IDLE and FRAME_END.
REQ-028 pixel_valid, frame_start and line_end form a delay pipeline of RD_LAT+1 stages from address issue.
- pixel is registered from mem_rdata on the pixel_valid edge.
- Reads already in flight complete during a stall.
REQ-029 frame_start marks pixel (0,0); line_end marks x=H_ACTIVE-1.

Reset
REQ-030 While reset=0: state=IDLE; x=y=0; mem_addr=0; pixel=0; pixel_valid=frame_start=line_end=0; active_buf=0; swap pending=0; pipeline cleared.
REQ-031 Reset asserted mid-frame aborts the scan immediately; in-flight reads produce no pixel_valid.
REQ-032 After release, the first scan starts at base0, pixel (0,0).

Structure
REQ-033 Package fb_pkg holds the state enum and the default H_ACTIVE, V_ACTIVE, STRIDE and ADDR_W constants.
REQ-034 One sub-module, fb_valid_pipe, delays the valid, frame_start and line_end flags by RD_LAT+1 stages.

Verification
REQ-035 H=4, V=2, STRIDE=8, base0=0x100, tick every cycle -> addresses 0x100..0x103, 0x108..0x10B; frame_start with the first pixel; line_end on the 4th and 8th pixels.
REQ-036 base0=0xFFFE, H=4 -> addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001 (wrap).
REQ-037 swap_req mid-frame, base1=0x200 -> current frame finishes on base0; next frame_start at 0x200; active_buf=1.
REQ-038 enable=0 for 5 cycles at x=2 -> x, y and mem_addr hold; no new pixel_valid; resumes at x=2.
REQ-039 reset=0 asserted at x=3, y=1 -> all outputs 0 in the same cycle; after release, restarts at base0.
REQ-040 RD_LAT=2 -> pixel_valid 3 cycles after issue; pixel equals the RAM model contents at the issued address.
